button_events: RTL and testbench
================================

// Module: button_events
// PURPOSE
//   Parametrised N-channel button front end. Debounces raw inputs on the shield
//   sample strobe and emits one-clock press, release and auto-repeat events per
//   channel. Successor to the fixed 4-button rising-edge block. Feeds the
//   interactive examples' control FSMs.
// PARAMETERS
//   N_BTN        4   number of button channels
//   ACTIVE_LOW   0   1: invert btn before processing (pressed = 0 on pin)
//   DEB_TICKS    4   consecutive differing samples needed to flip level (>=1)
//   HOLD_TICKS   200 ticks the level must stay high before the first repeat (>=1)
//   RPT_TICKS    50  ticks between subsequent repeats (>=1)
//   RPT_EN       1   0: repeat machinery removed; rpt tied 0
// PORTS
//   clk           in   1      system clock
//   rst           in   1      synchronous reset, active-high
//   shield_ready  in   1      sample strobe (tick); may be high any number of cycles
//   btn           in   N_BTN  raw asynchronous button pins
//   level         out  N_BTN  debounced pressed state
//   press         out  N_BTN  1-cycle pulse on debounced 0->1
//   rel           out  N_BTN  1-cycle pulse on debounced 1->0
//   rpt           out  N_BTN  1-cycle pulse per auto-repeat while held
// BEHAVIOUR
//   - Reset: sync flops, level, level_d, all counters, FSMs=IDLE; press/rel/rpt/level=0.
//   - Input path: btn ^ {N_BTN{ACTIVE_LOW}} -> 2-flop synchroniser every clk (s = 2nd flop).
//   - Debounce per channel, evaluated only on clk edges with shield_ready=1:
//       s == level  -> deb_cnt <= 0
//       s != level  -> if deb_cnt == DEB_TICKS-1: level <= s, deb_cnt <= 0
//                      else deb_cnt <= deb_cnt+1
//     shield_ready=0: deb_cnt and level hold. deb_cnt width $clog2(DEB_TICKS+1).
//   - Edge outputs registered from level: press = level & ~level_d, rel = ~level & level_d;
//     each high exactly one clk, the cycle after level changes.
//   - Latency pin->press: 2 clk sync + DEB_TICKS ticks + 1 clk.
//   - Repeat FSM per channel (RPT_EN=1), hold_cnt width $clog2(max(HOLD,RPT)+1):
//       IDLE : level=1 -> WAIT, hold_cnt<=0
//       WAIT : tick -> hold_cnt+1; when hold_cnt==HOLD_TICKS-1 on a tick: rpt pulse,
//              hold_cnt<=0, -> RPT
//       RPT  : tick -> hold_cnt+1; when hold_cnt==RPT_TICKS-1 on a tick: rpt pulse,
//              hold_cnt<=0
//       WAIT/RPT: level=0 -> IDLE, hold_cnt<=0, no rpt that cycle (release wins).
//     rpt registered, 1 clk wide; never coincides with press of same channel.
//   - Channels fully independent; simultaneous events on several channels all reported
//     in the same cycle.
//   - Bounce shorter than DEB_TICKS ticks: counter clears, no level change, no events.
//   - rst mid-press: all state cleared next clk, no rel pulse generated; a still-held
//     button is re-detected as press after full debounce latency.
//   - Counters never wrap: all comparisons are == terminal value then clear.
// TESTING
//   1 DEB_TICKS=4, tick every clk: btn[2] 0->1 steady -> press[2]=1 for 1 clk,
//     7 clk after the edge; level[2]=1; other channels silent.
//   2 btn[0] glitch high 3 ticks then low, DEB_TICKS=4 -> no press/rel, level[0]
//     stays 0.
//   3 HOLD_TICKS=10, RPT_TICKS=3: hold btn[1] 20 ticks -> first rpt 10 ticks after
//     press, then rpt at ticks 13,16,19; release -> rel pulse, no further rpt.
//   4 ACTIVE_LOW=1: pin 1->0 -> press; pin 0->1 -> rel; idle-high pins give no events
//     after reset.
//   5 all 4 buttons pressed same clk -> press=4'b1111 in one cycle; assert rst while
//     held -> outputs 0 next clk, no rel; deassert -> press=4'b1111 after latency.
//   6 shield_ready low for 100 clk while btn toggles -> no level change; ticks resume
//     -> debounce continues from held deb_cnt.

Source files
------------

// File: rtl/button_events.sv
// rtl/button_events.sv - N-channel button debouncer with press/release/auto-repeat events
module button_events #(
  parameter int N_BTN      = 4,
  parameter int ACTIVE_LOW = 0,
  parameter int DEB_TICKS  = 4,
  parameter int HOLD_TICKS = 200,
  parameter int RPT_TICKS  = 50,
  parameter int RPT_EN     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shield_ready,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] rel,
  output logic [N_BTN-1:0] rpt
);

  localparam int DW   = $clog2(DEB_TICKS + 1);
  localparam int HMAX = (HOLD_TICKS > RPT_TICKS) ? HOLD_TICKS : RPT_TICKS;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [N_BTN-1:0] INV      = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_TICKS - 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0]    RPT_LAST  = HW'(RPT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RPT  = 2'd2
  } rpt_state_t;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] level_d;
  logic [DW-1:0]    deb_cnt [N_BTN];

  // Two-flop synchroniser; polarity normalised so 1 always means pressed
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn ^ INV;
      sync2 <= sync1;
    end
  end

  // Debounce: level flips only after DEB_TICKS consecutive disagreeing ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      for (int i = 0; i < N_BTN; i++) deb_cnt[i] <= '0;
    end else if (shield_ready) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          level[i]   <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered edge detect on the debounced level
  always_ff @(posedge clk) begin
    if (rst) begin
      level_d <= '0;
      press   <= '0;
      rel     <= '0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
      rel     <= ~level & level_d;
    end
  end

  generate
    if (RPT_EN != 0) begin : g_rpt
      for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        rpt_state_t      state;
        rpt_state_t      state_nx;
        logic [HW-1:0]   hold_cnt;
        logic [HW-1:0]   hold_cnt_nx;
        logic            fire;
        logic            rpt_q;

        // Repeat FSM state, hold counter and registered repeat pulse
        always_ff @(posedge clk) begin
          if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rpt_q    <= 1'b0;
          end else begin
            state    <= state_nx;
            hold_cnt <= hold_cnt_nx;
            rpt_q    <= fire;
          end
        end

        // Next state: release always wins over a due repeat
        always_comb begin
          state_nx    = state;
          hold_cnt_nx = hold_cnt;
          fire        = 1'b0;
          case (state)
            IDLE: begin
              if (level[g]) begin
                state_nx    = WAIT;
                hold_cnt_nx = '0;
              end
            end
            WAIT: begin
              if (!level[g]) begin
                state_nx    = IDLE;
                hold_cnt_nx = '0;
              end else if (shield_ready) begin
                if (hold_cnt == HOLD_LAST) begin
                  fire        = 1'b1;
                  hold_cnt_nx = '0;
                  state_nx    = RPT;
                end else begin
                  hold_cnt_nx = hold_cnt + 1'b1;
                end
              end
            end
            RPT: begin
              if (!level[g]) begin
                state_nx    = IDLE;
                hold_cnt_nx = '0;
              end else if (shield_ready) begin
                if (hold_cnt == RPT_LAST) begin
                  fire        = 1'b1;
                  hold_cnt_nx = '0;
                end else begin
                  hold_cnt_nx = hold_cnt + 1'b1;
                end
              end
            end
            default: begin
              state_nx    = IDLE;
              hold_cnt_nx = '0;
            end
          endcase
        end

        assign rpt[g] = rpt_q;
      end
    end else begin : g_no_rpt
      assign rpt = '0;
    end
  endgenerate

endmodule

// File: tb/tb_button_events.sv
// tb/tb_button_events.sv - randomized model-checked bench for button_events
module tb_button_events;
  localparam int N    = 4;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int RPTT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic shield_ready = 1'b1;
  logic [N-1:0] btn = '0;
  logic [N-1:0] btn_n;
  logic [N-1:0] level, press, rel, rpt;
  logic [N-1:0] level_b, press_b, rel_b, rpt_b;

  assign btn_n = ~btn;

  always #5 clk = ~clk;

  button_events #(.N_BTN(N), .ACTIVE_LOW(0), .DEB_TICKS(DEB), .HOLD_TICKS(HOLD),
                  .RPT_TICKS(RPTT), .RPT_EN(1)) dut (
    .clk(clk), .rst(rst), .shield_ready(shield_ready), .btn(btn),
    .level(level), .press(press), .rel(rel), .rpt(rpt));

  button_events #(.N_BTN(N), .ACTIVE_LOW(1), .DEB_TICKS(DEB), .HOLD_TICKS(HOLD),
                  .RPT_TICKS(RPTT), .RPT_EN(1)) dut_al (
    .clk(clk), .rst(rst), .shield_ready(shield_ready), .btn(btn_n),
    .level(level_b), .press(press_b), .rel(rel_b), .rpt(rpt_b));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pipeline of pin samples, run-length debounce, tick count while held
  logic [N-1:0] m_h1 = '0, m_h2 = '0, m_lev = '0, m_levd = '0;
  logic [N-1:0] m_press = '0, m_rel = '0, m_rpt = '0, m_prev = '0;
  logic [N-1:0] m_s, m_lpre;
  int m_run [N];
  int m_held[N];

  always @(posedge clk) begin
    if (rst) begin
      m_h1 = '0; m_h2 = '0; m_lev = '0; m_levd = '0;
      m_press = '0; m_rel = '0; m_rpt = '0; m_prev = '0;
      for (int i = 0; i < N; i++) begin m_run[i] = 0; m_held[i] = 0; end
    end else begin
      m_s    = m_h2;
      m_lpre = m_lev;
      m_h2   = m_h1;
      m_h1   = btn;
      m_press = m_lpre & ~m_levd;
      m_rel   = ~m_lpre & m_levd;
      m_levd  = m_lpre;
      for (int i = 0; i < N; i++) begin
        if (shield_ready) begin
          if (m_s[i] == m_lpre[i]) m_run[i] = 0;
          else begin
            m_run[i]++;
            if (m_run[i] == DEB) begin m_lev[i] = m_s[i]; m_run[i] = 0; end
          end
        end
        m_rpt[i] = 1'b0;
        if (!m_lpre[i]) m_held[i] = 0;
        else if (m_prev[i] && shield_ready) begin
          m_held[i]++;
          if (m_held[i] == HOLD || (m_held[i] > HOLD && (m_held[i] - HOLD) % RPTT == 0))
            m_rpt[i] = 1'b1;
        end
      end
      m_prev = m_lpre;
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("level", level, m_lev);
      check("press", press, m_press);
      check("rel", rel, m_rel);
      check("rpt", rpt, m_rpt);
      check("al_level", level_b, m_lev);
      check("al_press", press_b, m_press);
      check("al_rel", rel_b, m_rel);
      check("al_rpt", rpt_b, m_rpt);
    end
  end

  int pc, c7, nrel, nrpt_late;
  int rq[$];
  logic [N-1:0] lev0;

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("reset_level", level, 4'b0000);
    check("reset_events", {press, rel, rpt}, 12'h000);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // press on channel 2, exact latency 7 clocks
    btn = 4'b0100;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("t1_press_timing", press, (k == 7) ? 4'b0100 : 4'b0000);
    end
    check("t1_level", level, 4'b0100);
    btn = 4'b0000;
    repeat (12) @(negedge clk);
    check("t1_released", level, 4'b0000);

    // 3-tick glitch on channel 0 is swallowed
    btn[0] = 1'b1;
    repeat (3) @(negedge clk);
    btn[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("t2_level", level, 4'b0000);

    // hold channel 1: repeats 10,13,16,19 clocks after press
    pc = -1000;
    btn[1] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (press[1]) pc = c;
      if (rpt[1]) rq.push_back(c - pc);
    end
    check("t3_rpt_count_ge4", rq.size() >= 4, 1);
    if (rq.size() >= 4) begin
      check("t3_rpt0", rq[0], 10);
      check("t3_rpt1", rq[1], 13);
      check("t3_rpt2", rq[2], 16);
      check("t3_rpt3", rq[3], 19);
    end
    btn[1] = 1'b0;
    nrel = 0; nrpt_late = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rel[1]) nrel++;
      if (c >= 6 && rpt[1]) nrpt_late++;
    end
    check("t3_rel_once", nrel, 1);
    check("t3_no_rpt_after_release", nrpt_late, 0);

    // all pressed, reset while held, re-detected after full latency
    btn = 4'b1111;
    repeat (12) @(negedge clk);
    check("t5_level_all", level, 4'b1111);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_level", level, 4'b0000);
    check("t5_rst_rel", rel, 4'b0000);
    rst = 1'b0;
    c7 = -1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (press == 4'b1111 && c7 < 0) c7 = c;
    end
    check("t5_repress_latency", c7, 7);
    btn = 4'b0000;
    repeat (14) @(negedge clk);

    // no ticks: level frozen while pins toggle
    lev0 = level;
    shield_ready = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      btn = 4'($urandom);
    end
    check("t6_frozen", level, lev0);
    shield_ready = 1'b1;
    repeat (20) @(negedge clk);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 29) == 0) btn[i] = ~btn[i];
      shield_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 799) == 0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
